// File: rtl/reset_sequencer_pkg.sv
// Shared types for the multi-channel reset sequencer.
// Holds the FSM state encoding used by the top.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_WAIT_ACK,
    ST_GAP,
    ST_DONE
  } state_e;

endpackage

// File: rtl/reset_sequencer_req_sync.sv
// Synchronizer for the async active-low external reset request.
// Flops reset to 1 so the request reads inactive out of reset.
module reset_req_sync #(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst_i) sync_q <= '1;
    else       sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Multi-channel reset sequencer: merged request, hold, then
// in-order channel release with gaps and optional ack waits.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int                CHANNELS       = 4,
  parameter int                SYNC_STAGES    = 3,
  parameter int                HOLD_CYCLES    = 16,
  parameter int                GAP_CYCLES     = 8,
  parameter int                TIMEOUT_CYCLES = 255,
  parameter logic [CHANNELS-1:0] ACK_MASK     = 4'b0010,
  parameter int                CNT_WIDTH      = 8
) (
  input  logic                clk,
  input  logic                rst_i,
  input  logic                ext_rst_req_n,
  input  logic                sw_rst_req,
  input  logic [CHANNELS-1:0] ch_ack,
  output logic [CHANNELS-1:0] rst_o,
  output logic                busy,
  output logic                timeout_o
);

  localparam int IW = $clog2(CHANNELS);
  localparam logic [IW-1:0] LAST = IW'(CHANNELS - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_END = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_END  = CNT_WIDTH'(GAP_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TMO_END  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_e                state_q;
  logic [IW-1:0]         idx_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CHANNELS-1:0]   rst_q;
  logic                  busy_q;
  logic                  tmo_q;

  logic                  ext_sync;
  logic                  req;
  logic [IW-1:0]         rel_idx;
  logic                  rel_mask;
  logic                  rel_last;
  logic                  wait_last;

  reset_req_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_i (rst_i),
    .d_i   (ext_rst_req_n),
    .q_o   (ext_sync)
  );

  assign req = rst_i | sw_rst_req | ~ext_sync;

  // Channel released on this edge: 0 out of ASSERT, idx+1 out of GAP.
  always_comb begin
    rel_idx = '0;
    if (state_q == ST_GAP) rel_idx = idx_q + 1'b1;
  end

  assign rel_mask  = ACK_MASK[rel_idx];
  assign rel_last  = (rel_idx == LAST);
  assign wait_last = (idx_q == LAST);

  always_ff @(posedge clk) begin
    if (req) begin
      state_q <= ST_ASSERT;
      idx_q   <= '0;
      cnt_q   <= '0;
      rst_q   <= '1;
      busy_q  <= 1'b1;
      if (rst_i) tmo_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_ASSERT, ST_GAP: begin
          if ((state_q == ST_ASSERT && cnt_q == HOLD_END) ||
              (state_q == ST_GAP && cnt_q == GAP_END)) begin
            rst_q[rel_idx] <= 1'b0;
            idx_q          <= rel_idx;
            cnt_q          <= '0;
            if (rel_mask)      state_q <= ST_WAIT_ACK;
            else if (rel_last) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
            end else           state_q <= ST_GAP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_WAIT_ACK: begin
          if (ch_ack[idx_q] || cnt_q == TMO_END) begin
            if (!ch_ack[idx_q]) tmo_q <= 1'b1;
            cnt_q <= '0;
            if (wait_last) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_GAP;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: ;
        default: state_q <= ST_ASSERT;
      endcase
    end
  end

  assign rst_o     = rst_q;
  assign busy      = busy_q;
  assign timeout_o = tmo_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer at default parameters.
// Edge numbers are counted from the last request edge of each phase.
module tb_reset_sequencer;

  logic       clk;
  logic       rst_i;
  logic       ext_rst_req_n;
  logic       sw_rst_req;
  logic [3:0] ch_ack;
  logic [3:0] rst_o;
  logic       busy;
  logic       timeout_o;

  int e;
  int npass;
  int ntot;

  reset_sequencer dut (
    .clk           (clk),
    .rst_i         (rst_i),
    .ext_rst_req_n (ext_rst_req_n),
    .sw_rst_req    (sw_rst_req),
    .ch_ack        (ch_ack),
    .rst_o         (rst_o),
    .busy          (busy),
    .timeout_o     (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic run_to(input int n);
    while (e < n) tick();
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s @%0d: got %0h want %0h", tag, e, obs, exp);
  endtask

  task automatic chk_all(input string tag, input logic [3:0] r,
                         input logic b, input logic t);
    chk({tag, ".rst"}, {4'b0, rst_o}, {4'b0, r});
    chk({tag, ".busy"}, {7'b0, busy}, {7'b0, b});
    chk({tag, ".tmo"}, {7'b0, timeout_o}, {7'b0, t});
  endtask

  initial begin
    e = 0;
    npass = 0;
    ntot = 0;
    rst_i = 1'b1;
    ext_rst_req_n = 1'b1;
    sw_rst_req = 1'b0;
    ch_ack = 4'b0000;
    repeat (4) @(posedge clk);
    #1;
    e = 0;
    chk_all("reset", 4'b1111, 1'b1, 1'b0);
    rst_i = 1'b0;

    // Plain release with ack[1] seen at edge 40
    run_to(15); chk_all("t1.e15", 4'b1111, 1'b1, 1'b0);
    run_to(16); chk_all("t1.e16", 4'b1110, 1'b1, 1'b0);
    run_to(23); chk("t1.e23", {4'b0, rst_o}, 8'h0e);
    run_to(24); chk("t1.e24", {4'b0, rst_o}, 8'h0c);
    run_to(39); chk("t1.e39", {4'b0, rst_o}, 8'h0c);
    ch_ack = 4'b0010;
    run_to(47); chk("t1.e47", {4'b0, rst_o}, 8'h0c);
    run_to(48); chk("t1.e48", {4'b0, rst_o}, 8'h08);
    run_to(55); chk_all("t1.e55", 4'b1000, 1'b1, 1'b0);
    run_to(56); chk_all("t1.e56", 4'b0000, 1'b0, 1'b0);
    ch_ack = 4'b0000;
    run_to(60); chk_all("t1.ackdrop", 4'b0000, 1'b0, 1'b0);

    // Restart, sw pulse at edge 30, then ack timeout
    rst_i = 1'b1;
    tick();
    e = 0;
    rst_i = 1'b0;
    chk_all("t3.rst", 4'b1111, 1'b1, 1'b0);
    run_to(29); chk("t3.e29", {4'b0, rst_o}, 8'h0c);
    sw_rst_req = 1'b1;
    run_to(30); chk_all("t3.e30", 4'b1111, 1'b1, 1'b0);
    sw_rst_req = 1'b0;
    run_to(45); chk("t3.e45", {4'b0, rst_o}, 8'h0f);
    run_to(46); chk("t3.e46", {4'b0, rst_o}, 8'h0e);
    run_to(54); chk("t2.e54", {4'b0, rst_o}, 8'h0c);
    run_to(308); chk_all("t2.e308", 4'b1100, 1'b1, 1'b0);
    run_to(309); chk_all("t2.e309", 4'b1100, 1'b1, 1'b1);
    run_to(316); chk("t2.e316", {4'b0, rst_o}, 8'h0c);
    run_to(317); chk("t2.e317", {4'b0, rst_o}, 8'h08);
    run_to(325); chk_all("t2.e325", 4'b0000, 1'b0, 1'b1);

    // sw request in DONE while ack toggles
    run_to(330); chk_all("t5.e330", 4'b0000, 1'b0, 1'b1);
    sw_rst_req = 1'b1;
    ch_ack = 4'b1111;
    run_to(331); chk_all("t5.e331", 4'b1111, 1'b1, 1'b1);
    sw_rst_req = 1'b0;
    ch_ack = 4'b0010;
    run_to(347); chk("t5.e347", {4'b0, rst_o}, 8'h0e);
    run_to(355); chk("t5.e355", {4'b0, rst_o}, 8'h0c);
    run_to(363); chk("t5.e363", {4'b0, rst_o}, 8'h0c);
    run_to(364); chk("t5.e364", {4'b0, rst_o}, 8'h08);
    run_to(372); chk_all("t5.e372", 4'b0000, 1'b0, 1'b1);
    ch_ack = 4'b0000;

    // External request low for edges 400..405
    run_to(399);
    ext_rst_req_n = 1'b0;
    run_to(402); chk_all("t4.e402", 4'b0000, 1'b0, 1'b1);
    run_to(403); chk_all("t4.e403", 4'b1111, 1'b1, 1'b1);
    run_to(405);
    ext_rst_req_n = 1'b1;
    run_to(423); chk("t4.e423", {4'b0, rst_o}, 8'h0f);
    run_to(424); chk("t4.e424", {4'b0, rst_o}, 8'h0e);
    run_to(432); chk("t4.e432", {4'b0, rst_o}, 8'h0c);

    // rst_i mid-wait clears the sticky timeout
    run_to(450); chk_all("t6.e450", 4'b1100, 1'b1, 1'b1);
    rst_i = 1'b1;
    tick();
    e = 0;
    rst_i = 1'b0;
    chk_all("t6.rst", 4'b1111, 1'b1, 1'b0);
    run_to(15); chk("t6.e15", {4'b0, rst_o}, 8'h0f);
    run_to(16); chk("t6.e16", {4'b0, rst_o}, 8'h0e);
    run_to(24); chk_all("t6.e24", 4'b1100, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
